// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 stream feeder front end.
package rc4_pkg;
  localparam int         KEY_BYTES = 16;
  localparam logic [7:0] NULL_CHAR = 8'h00;

  typedef enum logic [1:0] {KEY_LOAD, RELEASE, WAIT_INIT, STREAM} feeder_state_t;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/rc4_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; flush overrides push and pop.
module rc4_byte_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  byte_t       wdata,
  output byte_t       rdata,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  byte_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rc4_stream_feeder.sv
// Loads the RC4 key serially, sequences the decryptor reset, and streams
// buffered ciphertext into the core once its key schedule completes.
//
//   state     | meaning
//   KEY_LOAD  | collecting 16 key bytes, decryptor held in reset
//   RELEASE   | one cycle: release decryptor reset
//   WAIT_INIT | buffering input, waiting for init_done
//   STREAM    | popping one buffered byte per cycle into the core
module rc4_stream_feeder
  import rc4_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  byte_t            key_byte,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             rekey,
  input  byte_t            in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [FIFO_AW:0] fifo_count,
  output byte_t            seed [15:0],
  output logic             dec_rst_n,
  input  logic             init_done,
  output byte_t            din,
  output logic             din_valid
);

  localparam int IDX_W = $clog2(KEY_BYTES);

  feeder_state_t    state;
  logic [IDX_W-1:0] idx;
  logic             rekey_take;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  byte_t            fifo_head;

  assign key_ready  = (state == KEY_LOAD);
  assign in_ready   = (state != KEY_LOAD) && !fifo_full;
  assign rekey_take = rekey && (state != KEY_LOAD);
  assign fifo_push  = in_valid && in_ready;
  assign fifo_pop   = (state == STREAM) && !fifo_empty && !rekey_take;

  rc4_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (rekey_take),
    .wdata (in_byte),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= KEY_LOAD;
      idx       <= '0;
      dec_rst_n <= 1'b0;
      din       <= NULL_CHAR;
      din_valid <= 1'b0;
      for (int i = 0; i < KEY_BYTES; i++) seed[i] <= NULL_CHAR;
    end else begin
      din       <= NULL_CHAR;
      din_valid <= 1'b0;
      case (state)
        KEY_LOAD: begin
          if (key_valid) begin
            seed[idx] <= key_byte;
            idx       <= idx + 1'b1;
            if (idx == IDX_W'(KEY_BYTES - 1)) state <= RELEASE;
          end
        end
        RELEASE: begin
          dec_rst_n <= 1'b1;
          state     <= WAIT_INIT;
        end
        WAIT_INIT: begin
          if (init_done) state <= STREAM;
        end
        STREAM: begin
          if (fifo_pop) begin
            din       <= fifo_head;
            din_valid <= 1'b1;
          end
        end
        default: state <= KEY_LOAD;
      endcase
      // Re-key abandons everything; the old seed stays until overwritten.
      if (rekey_take) begin
        state     <= KEY_LOAD;
        idx       <= '0;
        dec_rst_n <= 1'b0;
        din       <= NULL_CHAR;
        din_valid <= 1'b0;
      end
    end
  end

endmodule
